// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and widths used by the ALU,
// the decoder and the ALU arbiter.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    localparam alu_op_e ALU_OP_LAST = ALU_SLTU;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU.
// Ports: a, b operands; op opcode (alu_op_e); y result; zero = (y == 0).
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [XLEN-1:0]     y,
    output logic                zero
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    logic            lt_s;
    logic            lt_u;

    assign shamt = b[SH_W-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
            default:  y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible index
// after rr_last, scanning cyclically. Ports: elig, rr_last in;
// gnt_onehot, gnt_idx (0 when no grant), gnt_any out.
module rr_arbiter #(
    parameter  int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] elig,
    input  logic [W-1:0] rr_last,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);

    always_comb begin
        int idx;
        idx        = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_any    = 1'b0;
        // k = N wraps back to rr_last itself, so it is checked last
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_last) + k) % N;
            if (!gnt_any && elig[idx]) begin
                gnt_any         = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = W'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters: round-robin, one grant per
// cycle, registered per-requester responses (1-cycle latency).
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_a/req_b/
// req_op request side; rsp_valid/rsp_ready/rsp_y/rsp_zero/rsp_err
// response side; busy = any response pending.
// Optional macro ALU_ARB_OPCHK_EN: opcodes above ALU_SLTU return
// rsp_err = 1, y = 0, zero = 1 instead of the ALU result.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int N_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*XLEN-1:0]     req_a,
    input  logic [N_REQ*XLEN-1:0]     req_b,
    input  logic [N_REQ*ALU_OP_W-1:0] req_op,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [N_REQ*XLEN-1:0]     rsp_y,
    output logic [N_REQ-1:0]          rsp_zero,
    output logic [N_REQ-1:0]          rsp_err,
    output logic                      busy
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [N_REQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [N_REQ-1:0][XLEN-1:0]  rsp_y_q, rsp_y_d;
    logic [N_REQ-1:0]            rsp_zero_q, rsp_zero_d;
    logic [PTR_W-1:0]            rr_last_q, rr_last_d;

    logic [N_REQ-1:0]    elig;
    logic [N_REQ-1:0]    gnt_onehot;
    logic [PTR_W-1:0]    gnt_idx;
    logic                gnt_any;

    logic [XLEN-1:0]     alu_a, alu_b, alu_y;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_zero;

    logic [XLEN-1:0]     res_y;
    logic                res_zero;

    // A slot is free if empty or drained this same cycle
    assign elig = req_valid
                & (~rsp_valid_q | rsp_ready)
                & {N_REQ{~rst}};

    rr_arbiter #(.N(N_REQ)) u_rr (
        .elig       (elig),
        .rr_last    (rr_last_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    assign req_ready = gnt_onehot;

    // Slice 0 drives the ALU when nobody is granted
    always_comb begin
        alu_a  = req_a[XLEN-1:0];
        alu_b  = req_b[XLEN-1:0];
        alu_op = req_op[ALU_OP_W-1:0];
        for (int i = 1; i < N_REQ; i++) begin
            if (gnt_onehot[i]) begin
                alu_a  = req_a[i*XLEN +: XLEN];
                alu_b  = req_b[i*XLEN +: XLEN];
                alu_op = req_op[i*ALU_OP_W +: ALU_OP_W];
            end
        end
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .op   (alu_op),
        .y    (alu_y),
        .zero (alu_zero)
    );

`ifdef ALU_ARB_OPCHK_EN
    logic             op_bad;
    logic [N_REQ-1:0] rsp_err_q, rsp_err_d;

    assign op_bad   = alu_op > ALU_OP_LAST;
    assign res_y    = op_bad ? '0 : alu_y;
    assign res_zero = op_bad | alu_zero;

    always_comb begin
        rsp_err_d = rsp_err_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_onehot[i]) begin
                rsp_err_d[i] = op_bad;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= '0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign res_y    = alu_y;
    assign res_zero = alu_zero;
    assign rsp_err  = '0;
`endif

    always_comb begin
        // Consumed responses drop; a same-cycle grant re-arms below
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rsp_y_d     = rsp_y_q;
        rsp_zero_d  = rsp_zero_q;
        rr_last_d   = rr_last_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_onehot[i]) begin
                rsp_valid_d[i] = 1'b1;
                rsp_y_d[i]     = res_y;
                rsp_zero_d[i]  = res_zero;
            end
        end
        if (gnt_any) begin
            rr_last_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            rsp_zero_q  <= '0;
            rr_last_q   <= PTR_W'(N_REQ - 1);
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_zero_q  <= rsp_zero_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = |rsp_valid_q;

endmodule
